// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: state encoding, master indices and default widths shared by the
// two-master Wishbone arbiter and its watchdog.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2,
    ABORT  = 2'd3
  } state_t;

  localparam logic MASTER0 = 1'b0;
  localparam logic MASTER1 = 1'b1;

  localparam int DEF_DATA_W = 128;
  localparam int DEF_ADR_W  = 5;

  // Wide enough for the largest legal TIMEOUT_CYCLES (65535).
  localparam int WD_CNT_W = 16;

endpackage

// File: rtl/wb_arb_timeout.sv
// wb_arb_timeout: ack watchdog; counts enabled cycles and flags the cycle in
// which the TIMEOUT_CYCLES-th consecutive unanswered cycle is reached.
module wb_arb_timeout
  import wb_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic count_en,
  input  logic clear,
  output logic expired
);

  logic [WD_CNT_W-1:0] count_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (count_en) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  // Combinational so the FSM moves to ABORT on the same edge the limit is hit.
  assign expired = count_en && (count_reg == WD_CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: two Wishbone masters sharing one slave, round-robin on contention.
// Define WB_ARB_TIMEOUT_EN to add the ack watchdog that aborts a stalled grant.
module wb_arbiter
  import wb_arb_pkg::*;
#(
  parameter int DATA_W         = DEF_DATA_W,
  parameter int ADR_W          = DEF_ADR_W,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              m0_strobe,
  input  logic              m0_we,
  input  logic [ADR_W-1:0]  m0_adr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_ack,
  output logic              m0_error,
  input  logic              m1_strobe,
  input  logic              m1_we,
  input  logic [ADR_W-1:0]  m1_adr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_ack,
  output logic              m1_error,
  output logic              s_strobe,
  output logic              s_we,
  output logic [ADR_W-1:0]  s_adr,
  output logic [DATA_W-1:0] s_wdata,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic              s_ack,
  input  logic              s_error,
  output logic [1:0]        grant
);

  state_t state_reg, state_next;
  logic   last_grant_reg, last_grant_next;
  logic   wd_expired;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("wb_arbiter: TIMEOUT_CYCLES must be within 1..65535");
  end

`ifdef WB_ARB_TIMEOUT_EN
  logic wd_count_en;

  assign wd_count_en = (((state_reg == GRANT0) && m0_strobe) ||
                        ((state_reg == GRANT1) && m1_strobe)) && !s_ack && !s_error;

  // Any cycle that is not an unanswered owned request restarts the count.
  wb_arb_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clock   (clock),
    .reset   (reset),
    .count_en(wd_count_en),
    .clear   (!wd_count_en),
    .expired (wd_expired)
  );
`else
  assign wd_expired = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg      <= IDLE;
      last_grant_reg <= MASTER1;
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    grant           = 2'b00;
    s_strobe        = 1'b0;
    s_we            = 1'b0;
    s_adr           = '0;
    s_wdata         = '0;
    m0_rdata        = '0;
    m0_ack          = 1'b0;
    m0_error        = 1'b0;
    m1_rdata        = '0;
    m1_ack          = 1'b0;
    m1_error        = 1'b0;

    case (state_reg)
      IDLE: begin
        if (m0_strobe && m1_strobe) begin
          state_next = (last_grant_reg == MASTER1) ? GRANT0 : GRANT1;
        end else if (m0_strobe) begin
          state_next = GRANT0;
        end else if (m1_strobe) begin
          state_next = GRANT1;
        end
      end

      GRANT0: begin
        grant    = 2'b01;
        s_strobe = m0_strobe;
        s_we     = m0_we;
        s_adr    = m0_adr;
        s_wdata  = m0_wdata;
        m0_rdata = s_rdata;
        m0_ack   = s_ack;
        m0_error = s_error;
        if (!m0_strobe) begin
          last_grant_next = MASTER0;
          state_next      = m1_strobe ? GRANT1 : IDLE;
        end else if (wd_expired) begin
          last_grant_next = MASTER0;
          state_next      = ABORT;
        end
      end

      GRANT1: begin
        grant    = 2'b10;
        s_strobe = m1_strobe;
        s_we     = m1_we;
        s_adr    = m1_adr;
        s_wdata  = m1_wdata;
        m1_rdata = s_rdata;
        m1_ack   = s_ack;
        m1_error = s_error;
        if (!m1_strobe) begin
          last_grant_next = MASTER1;
          state_next      = m0_strobe ? GRANT0 : IDLE;
        end else if (wd_expired) begin
          last_grant_next = MASTER1;
          state_next      = ABORT;
        end
      end

      ABORT: begin
        // last_grant was loaded with the aborted owner on entry.
        state_next = IDLE;
        if (last_grant_reg == MASTER0) begin
          grant    = 2'b01;
          m0_error = 1'b1;
        end else begin
          grant    = 2'b10;
          m1_error = 1'b1;
        end
      end

      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: table-driven cycle vectors plus per-master transfer scoreboard
// for wb_arbiter; the timeout sequence runs when WB_ARB_TIMEOUT_EN is defined.
module tb_wb_arbiter;

  localparam int DW = 128;
  localparam int AW = 5;
  localparam int TO = 8;

  typedef struct {
    logic          m0_stb, m0_we;
    logic [AW-1:0] m0_adr;
    logic [DW-1:0] m0_wd;
    logic          m1_stb, m1_we;
    logic [AW-1:0] m1_adr;
    logic [DW-1:0] m1_wd;
    logic          ack, err;
    logic [DW-1:0] rdata;
  } in_t;

  typedef struct {
    logic [1:0]    grant;
    logic          s_stb, s_we;
    logic [AW-1:0] s_adr;
    logic [DW-1:0] s_wd;
    logic          m0_ack, m1_ack, m0_err, m1_err;
    logic [DW-1:0] m0_rd, m1_rd;
  } out_t;

  typedef struct {
    in_t  i;
    out_t o;
  } vec_t;

  typedef struct {
    logic          we;
    logic [AW-1:0] adr;
    logic [DW-1:0] wd;
  } xfer_t;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          m0_strobe = 1'b0, m0_we = 1'b0, m0_ack, m0_error;
  logic [AW-1:0] m0_adr = '0;
  logic [DW-1:0] m0_wdata = '0, m0_rdata;
  logic          m1_strobe = 1'b0, m1_we = 1'b0, m1_ack, m1_error;
  logic [AW-1:0] m1_adr = '0;
  logic [DW-1:0] m1_wdata = '0, m1_rdata;
  logic          s_strobe, s_we;
  logic [AW-1:0] s_adr;
  logic [DW-1:0] s_wdata;
  logic [DW-1:0] s_rdata = '0;
  logic          s_ack = 1'b0, s_error = 1'b0;
  logic [1:0]    grant;

  int    n_cmp  = 0;
  int    n_fail = 0;
  xfer_t q0[$];
  xfer_t q1[$];
  vec_t  tbl[13];
  in_t   iz;
  out_t  oz;

  wb_arbiter #(
    .DATA_W(DW), .ADR_W(AW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock(clock), .reset(reset),
    .m0_strobe(m0_strobe), .m0_we(m0_we), .m0_adr(m0_adr), .m0_wdata(m0_wdata),
    .m0_rdata(m0_rdata), .m0_ack(m0_ack), .m0_error(m0_error),
    .m1_strobe(m1_strobe), .m1_we(m1_we), .m1_adr(m1_adr), .m1_wdata(m1_wdata),
    .m1_rdata(m1_rdata), .m1_ack(m1_ack), .m1_error(m1_error),
    .s_strobe(s_strobe), .s_we(s_we), .s_adr(s_adr), .s_wdata(s_wdata),
    .s_rdata(s_rdata), .s_ack(s_ack), .s_error(s_error), .grant(grant)
  );

  always #5 clock = ~clock;

  function automatic in_t mi(int a, int aw, int aa, int ad, int b, int bw, int ba, int bd,
                             int k, int e, int rd);
    in_t r;
    r.m0_stb = 1'(a);  r.m0_we = 1'(aw); r.m0_adr = AW'(aa); r.m0_wd = DW'(ad);
    r.m1_stb = 1'(b);  r.m1_we = 1'(bw); r.m1_adr = AW'(ba); r.m1_wd = DW'(bd);
    r.ack = 1'(k); r.err = 1'(e); r.rdata = DW'(rd);
    return r;
  endfunction

  function automatic out_t mo(int g, int ss, int sw, int sa, int sd, int a0, int a1,
                              int e0, int e1, int r0, int r1);
    out_t r;
    r.grant = 2'(g); r.s_stb = 1'(ss); r.s_we = 1'(sw); r.s_adr = AW'(sa); r.s_wd = DW'(sd);
    r.m0_ack = 1'(a0); r.m1_ack = 1'(a1); r.m0_err = 1'(e0); r.m1_err = 1'(e1);
    r.m0_rd = DW'(r0); r.m1_rd = DW'(r1);
    return r;
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, required 'h%0h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input out_t e);
    chk({tag, ".grant"},    DW'(grant),    DW'(e.grant));
    chk({tag, ".s_strobe"}, DW'(s_strobe), DW'(e.s_stb));
    chk({tag, ".s_we"},     DW'(s_we),     DW'(e.s_we));
    chk({tag, ".s_adr"},    DW'(s_adr),    DW'(e.s_adr));
    chk({tag, ".s_wdata"},  s_wdata,       e.s_wd);
    chk({tag, ".m0_ack"},   DW'(m0_ack),   DW'(e.m0_ack));
    chk({tag, ".m1_ack"},   DW'(m1_ack),   DW'(e.m1_ack));
    chk({tag, ".m0_error"}, DW'(m0_error), DW'(e.m0_err));
    chk({tag, ".m1_error"}, DW'(m1_error), DW'(e.m1_err));
    chk({tag, ".m0_rdata"}, m0_rdata,      e.m0_rd);
    chk({tag, ".m1_rdata"}, m1_rdata,      e.m1_rd);
  endtask

  // A rising strobe opens a new request; record what the slave must later see.
  task automatic drive(input in_t i);
    xfer_t x;
    if (i.m0_stb && !m0_strobe) begin
      x.we = i.m0_we; x.adr = i.m0_adr; x.wd = i.m0_wd;
      q0.push_back(x);
    end
    if (i.m1_stb && !m1_strobe) begin
      x.we = i.m1_we; x.adr = i.m1_adr; x.wd = i.m1_wd;
      q1.push_back(x);
    end
    m0_strobe = i.m0_stb; m0_we = i.m0_we; m0_adr = i.m0_adr; m0_wdata = i.m0_wd;
    m1_strobe = i.m1_stb; m1_we = i.m1_we; m1_adr = i.m1_adr; m1_wdata = i.m1_wd;
    s_ack = i.ack; s_error = i.err; s_rdata = i.rdata;
  endtask

  task automatic apply(input string tag, input in_t i, input out_t o);
    @(posedge clock);
    #1;
    drive(i);
    @(negedge clock);
    check_out(tag, o);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    m0_strobe = 1'b1; m1_strobe = 1'b1; m0_we = 1'b1; m1_we = 1'b1;
    m0_adr = '1; m1_adr = '1; m0_wdata = '1; m1_wdata = '1;
    s_ack = 1'b1; s_error = 1'b1; s_rdata = '1;
    #1;
    check_out("reset", oz);
    m0_strobe = 1'b0; m1_strobe = 1'b0; m0_we = 1'b0; m1_we = 1'b0;
    m0_adr = '0; m1_adr = '0; m0_wdata = '0; m1_wdata = '0;
    s_ack = 1'b0; s_error = 1'b0; s_rdata = '0;
    q0.delete();
    q1.delete();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic sb_pop(input int n);
    xfer_t x;
    n_cmp++;
    if ((n == 0 && q0.size() == 0) || (n == 1 && q1.size() == 0)) begin
      n_fail++;
      $display("FAIL sb_m%0d_response: got ack/error, required no outstanding request", n);
      return;
    end
    if (n == 0) x = q0.pop_front();
    else x = q1.pop_front();
    chk($sformatf("sb_m%0d_grant", n), DW'(grant[n]), DW'(1));
    if (s_strobe) begin
      chk($sformatf("sb_m%0d_adr", n), DW'(s_adr), DW'(x.adr));
      chk($sformatf("sb_m%0d_we", n), DW'(s_we), DW'(x.we));
      if (x.we) chk($sformatf("sb_m%0d_wdata", n), s_wdata, x.wd);
    end
  endtask

  always @(negedge clock) begin
    if (reset) begin
      if (m0_ack || m0_error) sb_pop(0);
      if (m1_ack || m1_error) sb_pop(1);
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation still running, required $finish");
    $fatal(1, "tb_wb_arbiter: time limit expired");
  end

  initial begin
    iz = mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    oz = mo(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    tbl[0]  = '{mi(1, 1, 3, 'hA5, 0, 0, 0, 0, 0, 0, 0),       oz};
    tbl[1]  = '{mi(1, 1, 3, 'hA5, 0, 0, 0, 0, 0, 0, 0),       mo(1, 1, 1, 3, 'hA5, 0, 0, 0, 0, 0, 0)};
    tbl[2]  = '{mi(1, 1, 3, 'hA5, 0, 0, 0, 0, 0, 0, 0),       mo(1, 1, 1, 3, 'hA5, 0, 0, 0, 0, 0, 0)};
    tbl[3]  = '{mi(1, 1, 3, 'hA5, 0, 0, 0, 0, 1, 0, 0),       mo(1, 1, 1, 3, 'hA5, 1, 0, 0, 0, 0, 0)};
    tbl[4]  = '{iz,                                           mo(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[5]  = '{mi(1, 1, 3, 'h77, 1, 0, 18, 0, 0, 0, 0),      oz};
    tbl[6]  = '{mi(1, 1, 3, 'h77, 1, 0, 18, 0, 0, 0, 'h1234), mo(2, 1, 0, 18, 0, 0, 0, 0, 0, 0, 'h1234)};
    tbl[7]  = '{mi(1, 1, 3, 'h77, 1, 0, 18, 0, 1, 0, 'hBEEF), mo(2, 1, 0, 18, 0, 0, 1, 0, 0, 0, 'hBEEF)};
    tbl[8]  = '{mi(1, 1, 3, 'h77, 0, 0, 0, 0, 0, 0, 0),       mo(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[9]  = '{mi(1, 1, 3, 'h77, 0, 0, 0, 0, 0, 0, 0),       mo(1, 1, 1, 3, 'h77, 0, 0, 0, 0, 0, 0)};
    tbl[10] = '{mi(1, 1, 3, 'h77, 0, 0, 0, 0, 0, 1, 0),       mo(1, 1, 1, 3, 'h77, 0, 0, 1, 0, 0, 0)};
    tbl[11] = '{iz,                                           mo(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[12] = '{iz,                                           oz};

    do_reset();
    for (int k = 0; k < 13; k++) apply($sformatf("vec%0d", k), tbl[k].i, tbl[k].o);

    // Contention straight out of reset, zero-bubble handover, round-robin.
    do_reset();
    apply("rr_a0",  mi(1, 1, 1, 'h11, 1, 1, 2, 'h22, 0, 0, 0), oz);
    apply("rr_a1",  mi(1, 1, 1, 'h11, 1, 1, 2, 'h22, 0, 0, 0), mo(1, 1, 1, 1, 'h11, 0, 0, 0, 0, 0, 0));
    apply("rr_a2",  mi(1, 1, 1, 'h11, 1, 1, 2, 'h22, 1, 0, 0), mo(1, 1, 1, 1, 'h11, 1, 0, 0, 0, 0, 0));
    apply("rr_a3",  mi(0, 0, 0, 0, 1, 1, 2, 'h22, 0, 0, 0),    mo(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    apply("rr_a4",  mi(0, 0, 0, 0, 1, 1, 2, 'h22, 0, 0, 0),    mo(2, 1, 1, 2, 'h22, 0, 0, 0, 0, 0, 0));
    apply("rr_a5",  mi(0, 0, 0, 0, 1, 1, 2, 'h22, 1, 0, 0),    mo(2, 1, 1, 2, 'h22, 0, 1, 0, 0, 0, 0));
    apply("rr_a6",  iz,                                        mo(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    apply("rr_a7",  mi(1, 1, 4, 'h33, 1, 1, 5, 'h44, 0, 0, 0), oz);
    apply("rr_a8",  mi(1, 1, 4, 'h33, 1, 1, 5, 'h44, 0, 0, 0), mo(1, 1, 1, 4, 'h33, 0, 0, 0, 0, 0, 0));
    apply("rr_a9",  mi(1, 1, 4, 'h33, 1, 1, 5, 'h44, 1, 0, 0), mo(1, 1, 1, 4, 'h33, 1, 0, 0, 0, 0, 0));
    apply("rr_a10", mi(0, 0, 0, 0, 1, 1, 5, 'h44, 0, 0, 0),    mo(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    apply("rr_a11", mi(0, 0, 0, 0, 1, 1, 5, 'h44, 0, 0, 0),    mo(2, 1, 1, 5, 'h44, 0, 0, 0, 0, 0, 0));
    apply("rr_a12", mi(0, 0, 0, 0, 1, 1, 5, 'h44, 1, 0, 0),    mo(2, 1, 1, 5, 'h44, 0, 1, 0, 0, 0, 0));
    apply("rr_a13", iz,                                        mo(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    apply("rr_a14", iz,                                        oz);

`ifdef WB_ARB_TIMEOUT_EN
    // Slave never answers: eight owned cycles, one ABORT cycle, then IDLE.
    apply("to_d0", mi(1, 0, 16, 0, 0, 0, 0, 0, 0, 0, 0), oz);
    for (int k = 0; k < TO; k++)
      apply($sformatf("to_wait%0d", k), mi(1, 0, 16, 0, 0, 0, 0, 0, 0, 0, 0),
            mo(1, 1, 0, 16, 0, 0, 0, 0, 0, 0, 0));
    apply("to_abort", mi(1, 0, 16, 0, 0, 0, 0, 0, 0, 0, 0), mo(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    apply("to_idle", iz, oz);
`else
    // Long slave stall: m1 waits with no response, grant never times out.
    apply("hold_b0", mi(1, 1, 7, 'h55, 0, 0, 0, 0, 0, 0, 0), oz);
    for (int k = 0; k < 40; k++)
      apply($sformatf("hold_wait%0d", k), mi(1, 1, 7, 'h55, 1, 0, 18, 0, 0, 0, 0),
            mo(1, 1, 1, 7, 'h55, 0, 0, 0, 0, 0, 0));
    apply("hold_ack",   mi(1, 1, 7, 'h55, 1, 0, 18, 0, 1, 0, 'h9), mo(1, 1, 1, 7, 'h55, 1, 0, 0, 0, 'h9, 0));
    apply("hold_rel",   mi(0, 0, 0, 0, 1, 0, 18, 0, 0, 0, 0),      mo(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    apply("hold_m1",    mi(0, 0, 0, 0, 1, 0, 18, 0, 0, 0, 'h42),   mo(2, 1, 0, 18, 0, 0, 0, 0, 0, 0, 'h42));
    apply("hold_m1ack", mi(0, 0, 0, 0, 1, 0, 18, 0, 1, 0, 'h42),   mo(2, 1, 0, 18, 0, 0, 1, 0, 0, 0, 'h42));
    apply("hold_end",   iz,                                        mo(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    apply("hold_idle",  iz,                                        oz);
`endif

    // Reset asserted mid-GRANT1 while the slave is acking.
    apply("rst_c0", mi(0, 0, 0, 0, 1, 1, 9, 'h66, 0, 0, 0), oz);
    apply("rst_c1", mi(0, 0, 0, 0, 1, 1, 9, 'h66, 0, 0, 0), mo(2, 1, 1, 9, 'h66, 0, 0, 0, 0, 0, 0));
    #1;
    s_ack = 1'b1;
    s_rdata = DW'(32'hCC);
    reset = 1'b0;
    #1;
    check_out("rst_async", oz);
    q0.delete();
    q1.delete();
    drive(iz);
    @(negedge clock);
    check_out("rst_held", oz);
    reset = 1'b1;
    apply("rel_c0", mi(1, 1, 1, 'h10, 1, 1, 9, 'h66, 0, 0, 0), oz);
    apply("rel_c1", mi(1, 1, 1, 'h10, 1, 1, 9, 'h66, 0, 0, 0), mo(1, 1, 1, 1, 'h10, 0, 0, 0, 0, 0, 0));
    apply("rel_c2", mi(1, 1, 1, 'h10, 1, 1, 9, 'h66, 1, 0, 0), mo(1, 1, 1, 1, 'h10, 1, 0, 0, 0, 0, 0));
    apply("rel_c3", mi(0, 0, 0, 0, 1, 1, 9, 'h66, 0, 0, 0),    mo(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    apply("rel_c4", mi(0, 0, 0, 0, 1, 1, 9, 'h66, 0, 0, 0),    mo(2, 1, 1, 9, 'h66, 0, 0, 0, 0, 0, 0));
    apply("rel_c5", mi(0, 0, 0, 0, 1, 1, 9, 'h66, 1, 0, 0),    mo(2, 1, 1, 9, 'h66, 0, 1, 0, 0, 0, 0));
    apply("rel_c6", iz,                                        mo(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    apply("rel_c7", iz,                                        oz);

    chk("sb_q0_drained", DW'(q0.size()), DW'(0));
    chk("sb_q1_drained", DW'(q1.size()), DW'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter DATA_W, default 128, Wishbone data width.
REQ-002 Parameter ADR_W, default 5, Wishbone address width.
REQ-003 Parameter TIMEOUT_CYCLES, default 255, ack watchdog limit (range 1..65535).
REQ-004 clock  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 m0_strobe, m0_we  input  1 each  master 0 cycle request and write enable.
REQ-007 m0_adr  input  ADR_W;  m0_wdata  input  DATA_W  master 0 address and write data.
REQ-008 m0_rdata  output  DATA_W;  m0_ack, m0_error  output  1 each  master 0 responses.
REQ-009 m1_strobe, m1_we, m1_adr, m1_wdata, m1_rdata, m1_ack, m1_error  same as the m0_* ports, for master 1.
REQ-010 s_strobe, s_we  output  1;  s_adr  output  ADR_W;  s_wdata  output  DATA_W  shared slave request.
REQ-011 s_rdata  input  DATA_W;  s_ack, s_error  input  1 each  shared slave responses.
REQ-012 grant  output  2  one-hot owner: bit0 = master 0, bit1 = master 1, 00 = none.

Function
REQ-013 The FSM SHALL have the states IDLE, GRANT0, GRANT1 and ABORT.
REQ-014 IDLE: grant=00; all s_* outputs 0; all m*_ack, m*_error and m*_rdata 0.
REQ-015 IDLE, exactly one master strobing: next state is that master's GRANT (1-cycle arbitration latency).
REQ-016 IDLE, both masters strobing: grant SHALL go to the master not in last_grant (round-robin); after reset, master 0 wins.
REQ-017 GRANTn: s_strobe, s_we, s_adr, s_wdata SHALL be combinationally routed from master n.
REQ-018 GRANTn: s_rdata, s_ack, s_error SHALL be routed to master n only; the other master's responses are held at 0.
REQ-019 GRANTn: ownership SHALL be held while mn_strobe=1, including long ack-low waits by the slave (command/data execution).
REQ-020 GRANTn with mn_strobe=0: last_grant<=n; next state is the other master's GRANT if it is strobing, else IDLE; there is no bubble cycle on handover.
REQ-021 GRANTn with mn_strobe=0: s_strobe SHALL be 0 in that same cycle.
REQ-022 Requests arriving while another master owns the bus SHALL wait, and SHALL see ack=0 and error=0.
REQ-023 Address and data SHALL pass through unmodified, with no width conversion and no registering.

Reset
REQ-024 reset=0 SHALL asynchronously force state=IDLE, last_grant=1 (master 0 wins first), watchdog=0, and all outputs to 0.
REQ-025 Reset asserted mid-transfer SHALL abandon the transfer; no ack or error is issued for it.
REQ-026 Release of reset SHALL take effect at the next rising edge; the first possible grant is one cycle later.

Configuration
REQ-027 Macro WB_ARB_TIMEOUT_EN, when defined, compiles in the ack watchdog.
REQ-028 Watchdog counting: in GRANTn it counts cycles with mn_strobe=1 and s_ack=0 and s_error=0; it clears on ack, on error, and on leaving GRANTn.
REQ-029 Watchdog expiry: when the count reaches TIMEOUT_CYCLES, next state is ABORT.
REQ-030 ABORT lasts exactly one cycle: s_strobe=0, mn_error=1, mn_ack=0, grant keeps the aborted owner, last_grant<=n, then IDLE.
REQ-031 Without WB_ARB_TIMEOUT_EN, ABORT is unreachable, no counter is synthesized, and a grant is held indefinitely.

Structure
REQ-032 Package wb_arb_pkg SHALL hold: state encoding (IDLE=0, GRANT0=1, GRANT1=2, ABORT=3), master index constants, and default ADR_W/DATA_W.
REQ-033 The watchdog SHALL be a sub-module wb_arb_timeout (inputs: count enable, clear; output: expired), instantiated only under WB_ARB_TIMEOUT_EN.

Verification
REQ-034 m0 write adr=5'd3 data=128'hA5; slave acks 2 cycles later -> grant=01 the cycle after the strobe; s_adr=3, s_wdata=A5; m0_ack=1, m1_ack=0.
REQ-035 m0 and m1 strobe together from reset -> GRANT0 first; on m0 release, GRANT1 with no idle cycle; next contention -> m0 wins.
REQ-036 m1 read adr=5'd18 while m0 holds the bus with slave ack low for 40 cycles -> m1 sees ack=0 throughout; grant moves to m1 after m0 drops its strobe.
REQ-037 WB_ARB_TIMEOUT_EN with TIMEOUT_CYCLES=8; m0 strobe to adr=5'd16 with no ack -> after 8 cycles, m0_error=1 for one cycle, s_strobe=0, then IDLE.
REQ-038 reset=0 asserted mid-GRANT1 -> all outputs 0 before the next clock edge, grant=00; after release, m0 wins the first contention.
